rr_mux_sched: RTL and testbench

RR_MUX_SCHED -- requirements
Module: rr_mux_sched

---
 rtl/rr_mux_sched.sv | 78 +++++++
 tb/tb_rr_mux_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_sched.sv
// Four-channel round-robin scheduler feeding a registered 4:1 mux.
// A grant is held until the consumer takes it; the next grant loads on the same edge.
module rr_mux_sched #(
    parameter int width  = 4,
    parameter int swidth = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [width-1:0]  i0,
    input  logic [width-1:0]  i1,
    input  logic [width-1:0]  i2,
    input  logic [width-1:0]  i3,
    input  logic              o_ready,
    output logic [swidth-1:0] sel,
    output logic [width-1:0]  o,
    output logic              o_valid,
    output logic [3:0]        ack,
    output logic [7:0]        cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]              state;
    logic [swidth-1:0]       ptr;
    logic [3:0][width-1:0]   ch;
    logic                    done;
    logic                    load;
    logic                    gnt_v;
    logic [swidth-1:0]       gnt;
    logic [swidth-1:0]       idx;

    assign ch      = {i3, i2, i1, i0};
    assign o_valid = (state == HOLD);
    assign done    = o_valid && o_ready;

    // Offsets 1..4 from ptr; offset 4 wraps back to ptr itself, so a
    // lone held request on the last-served channel is re-granted.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = ptr;
        for (int j = 1; j <= 4; j++) begin
            idx = ptr + swidth'(j);
            if (!gnt_v && req[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign load = gnt_v && ((state == IDLE) || done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            o     <= '0;
            ptr   <= swidth'(3);
            cnt   <= '0;
        end else begin
            if (done)
                cnt <= cnt + 8'd1;
            if (load) begin
                state <= HOLD;
                sel   <= gnt;
                o     <= ch[gnt];
                ptr   <= gnt;
            end else if (done) begin
                state <= IDLE;
            end
        end
    end

    assign ack = (done && !reset) ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Directed bench for rr_mux_sched: a cycle-level model checked every cycle,
// plus hand-computed literal expectations along each directed scenario.
module tb_rr_mux_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] i0 = 4'h0, i1 = 4'h0, i2 = 4'h0, i3 = 4'h0;
    logic       o_ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] o;
    logic       o_valid;
    logic [3:0] ack;
    logic [7:0] cnt;

    int n_chk = 0;
    int n_fail = 0;

    rr_mux_sched #(.width(4), .swidth(2)) dut (
        .clk(clk), .reset(reset), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .o_ready(o_ready), .sel(sel), .o(o), .o_valid(o_valid),
        .ack(ack), .cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pending flag, granted channel, held data, last-served pointer, count.
    int m_v = 0, m_sel = 0, m_o = 0, m_ptr = 3, m_cnt = 0;

    function automatic int chan(input int k);
        case (k)
            0: return int'(i0);
            1: return int'(i1);
            2: return int'(i2);
            default: return int'(i3);
        endcase
    endfunction

    always @(posedge clk) begin
        int g;
        bit fin;
        if (reset) begin
            m_v = 0; m_sel = 0; m_o = 0; m_ptr = 3; m_cnt = 0;
        end else begin
            fin = (m_v != 0) && o_ready;
            if (fin) m_cnt = (m_cnt + 1) % 256;
            if (m_v == 0 || fin) begin
                g = -1;
                for (int j = 1; j <= 4; j++)
                    if (g < 0 && req[(m_ptr + j) % 4]) g = (m_ptr + j) % 4;
                if (g >= 0) begin
                    m_v = 1; m_sel = g; m_o = chan(g); m_ptr = g;
                end else begin
                    m_v = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int ea;
        ea = (!reset && m_v != 0 && o_ready) ? (1 << m_sel) : 0;
        chk("m_valid", 32'(o_valid), 32'(m_v));
        chk("m_ack", 32'(ack), 32'(ea));
        chk("m_cnt", 32'(cnt), 32'(m_cnt));
        if (m_v != 0 || !reset) begin
            chk("m_sel", 32'(sel), 32'(m_sel));
            chk("m_o", 32'(o), 32'(m_o));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [3:0] seq_o [5];

    initial begin
        seq_o[0] = 4'hA; seq_o[1] = 4'hB; seq_o[2] = 4'hC; seq_o[3] = 4'hD; seq_o[4] = 4'hA;

        // reset, then idle with no requests
        step(); step();
        smp();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_o", 32'(o), 0);
        chk("rst_cnt", 32'(cnt), 0);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step(); smp();
            chk("idle_valid", 32'(o_valid), 0);
            chk("idle_ack", 32'(ack), 0);
        end
        chk("idle_cnt", 32'(cnt), 0);

        // all channels requesting, consumer always ready
        req = 4'b1111; i0 = 4'hA; i1 = 4'hB; i2 = 4'hC; i3 = 4'hD; o_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step(); smp();
            chk("rr_o", 32'(o), 32'(seq_o[n]));
            chk("rr_sel", 32'(sel), 32'(n % 4));
            chk("rr_valid", 32'(o_valid), 1);
            chk("rr_cnt", 32'(cnt), 32'(n));
        end

        // hold under backpressure while data changes
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0100; i2 = 4'hC; o_ready = 1'b0;
        step();
        for (int n = 0; n < 5; n++) begin
            if (n == 2) i2 = 4'hF;
            smp();
            chk("bp_o", 32'(o), 32'hC);
            chk("bp_sel", 32'(sel), 2);
            chk("bp_ack", 32'(ack), 0);
            step();
        end
        o_ready = 1'b1; req = 4'b0000;
        smp();
        chk("bp_ack_pulse", 32'(ack), 32'b0100);
        step(); smp();
        chk("bp_cnt", 32'(cnt), 1);
        chk("bp_idle_valid", 32'(o_valid), 0);
        chk("bp_idle_sel", 32'(sel), 2);
        chk("bp_idle_o", 32'(o), 32'hC);
        chk("bp_ack_gone", 32'(ack), 0);

        // lone held request re-granted, then channel 0 ahead of 3
        req = 4'b1000; i3 = 4'hD; i0 = 4'hA;
        step(); smp();
        chk("rg_sel_a", 32'(sel), 3);
        step(); smp();
        chk("rg_sel_b", 32'(sel), 3);
        chk("rg_cnt", 32'(cnt), 2);
        req = 4'b1001;
        step(); smp();
        chk("rg_sel_0", 32'(sel), 0);
        chk("rg_o_0", 32'(o), 32'hA);
        step(); smp();
        chk("rg_sel_3", 32'(sel), 3);

        // reset during a pending transfer
        o_ready = 1'b0; req = 4'b1111;
        step();
        reset = 1'b1; o_ready = 1'b1;
        smp();
        chk("rh_ack_masked", 32'(ack), 0);
        step(); smp();
        chk("rh_valid", 32'(o_valid), 0);
        chk("rh_sel", 32'(sel), 0);
        chk("rh_o", 32'(o), 0);
        chk("rh_cnt", 32'(cnt), 0);
        reset = 1'b0;
        step(); smp();
        chk("rh_first", 32'(sel), 0);
        chk("rh_first_o", 32'(o), 32'hA);

        // counter wrap
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b1111; o_ready = 1'b1;
        step();
        for (int n = 0; n < 255; n++) step();
        smp();
        chk("wrap_255", 32'(cnt), 255);
        step(); smp();
        chk("wrap_0", 32'(cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
